game_physics_ctrl: RTL and testbench

GAME_PHYSICS_CTRL -- requirements
Module: game_physics_ctrl

---
 rtl/game_physics_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_physics_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_physics_ctrl.sv
// Player physics, obstacle collision and lives/score bookkeeping for a flap-style game.
// Everything advances once per frame_tick, and only while the mode FSM sits in PLAY.
module game_physics_ctrl #(
  parameter int N_OBS         = 10,
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int UPPER_BOUND   = 20,
  parameter int LOWER_BOUND   = 460,
  parameter int PLAYER_SIZE   = 40,
  parameter int PLAYER_X      = 100,
  parameter int START_Y       = 220,
  parameter int MAX_VELOCITY  = 8,
  parameter int ACCELERATION  = 1,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 30,
  parameter int SCORE_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic [2:0]                    sw,
  input  logic [N_OBS*2*X_W-1:0]        obstacle_x,
  input  logic [N_OBS*2*Y_W-1:0]        obstacle_y,
  output logic [1:0]                    gamemode,
  output logic [Y_W-1:0]                player_y,
  output logic [$clog2(LIVES+1)-1:0]    lives_left,
  output logic [SCORE_W-1:0]            score,
  output logic                          invuln,
  output logic                          hit_pulse
);
  localparam int LIVES_W = $clog2(LIVES+1);
  localparam int INV_W   = $clog2(INVULN_FRAMES+1);
  localparam int VEL_W   = $clog2(MAX_VELOCITY+ACCELERATION+1);
  localparam int SY_W    = Y_W + 2;

  localparam logic signed [SY_W-1:0] Y_MIN = SY_W'(UPPER_BOUND);
  localparam logic signed [SY_W-1:0] Y_MAX = SY_W'(LOWER_BOUND - PLAYER_SIZE);
  localparam logic [31:0] PX_LO = 32'(PLAYER_X);
  localparam logic [31:0] PX_HI = 32'(PLAYER_X + PLAYER_SIZE);
  localparam logic [31:0] PSIZE = 32'(PLAYER_SIZE);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  state_e                state_q;
  logic [Y_W-1:0]        y_q, y_d;
  logic [VEL_W-1:0]      vel_q, vel_d, vel_acc_s;
  logic                  dir_q, dir_d, clamp_s;
  logic [LIVES_W-1:0]    lives_q;
  logic [SCORE_W-1:0]    score_q;
  logic [INV_W-1:0]      inv_q;
  logic                  hit_pulse_q;
  logic                  overlap_s, hit_s, tick_play_s, last_life_s;
  logic signed [SY_W-1:0] y_raw_s, vel_signed_s;

  // dir=1 means moving down; gravity wins whenever flap is released
  always_comb begin
    vel_acc_s = vel_q + VEL_W'(ACCELERATION);
    if (dir_q == ~sw[0]) begin
      dir_d = dir_q;
      vel_d = (vel_acc_s > VEL_W'(MAX_VELOCITY)) ? VEL_W'(MAX_VELOCITY) : vel_acc_s;
    end else if (vel_q >= VEL_W'(ACCELERATION)) begin
      dir_d = dir_q;
      vel_d = vel_q - VEL_W'(ACCELERATION);
    end else begin
      dir_d = ~dir_q;
      vel_d = VEL_W'(ACCELERATION) - vel_q;
    end
    vel_signed_s = $signed({{(SY_W-VEL_W){1'b0}}, vel_d});
    y_raw_s      = $signed({2'b00, y_q}) + (dir_d ? vel_signed_s : -vel_signed_s);
    if (y_raw_s < Y_MIN) begin
      y_d     = Y_MIN[Y_W-1:0];
      clamp_s = 1'b1;
    end else if (y_raw_s > Y_MAX) begin
      y_d     = Y_MAX[Y_W-1:0];
      clamp_s = 1'b1;
    end else begin
      y_d     = y_raw_s[Y_W-1:0];
      clamp_s = 1'b0;
    end
  end

  // Inclusive box overlap against the pre-update player position
  always_comb begin
    overlap_s = 1'b0;
    for (int k = 0; k < N_OBS; k++) begin
      overlap_s = overlap_s
        | ((32'(obstacle_x[k*2*X_W +: X_W]) <= PX_HI)
        &  (32'(obstacle_x[k*2*X_W+X_W +: X_W]) >= PX_LO)
        &  (32'(obstacle_y[k*2*Y_W +: Y_W]) <= 32'(y_q) + PSIZE)
        &  (32'(obstacle_y[k*2*Y_W+Y_W +: Y_W]) >= 32'(y_q)));
    end
  end

  assign tick_play_s = frame_tick && (state_q == ST_PLAY);
  assign hit_s       = overlap_s && (inv_q == INV_W'(0));
  assign last_life_s = hit_s && (lives_q == LIVES_W'(1));

  // Mode FSM plus the frame-gated physics/lives/score state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      y_q         <= Y_W'(START_Y);
      vel_q       <= VEL_W'(0);
      dir_q       <= 1'b0;
      lives_q     <= LIVES_W'(LIVES);
      score_q     <= SCORE_W'(0);
      inv_q       <= INV_W'(0);
      hit_pulse_q <= 1'b0;
    end else if (sw[2:1] == 2'b00) begin
      state_q     <= ST_INIT;
      y_q         <= Y_W'(START_Y);
      vel_q       <= VEL_W'(0);
      dir_q       <= 1'b0;
      lives_q     <= LIVES_W'(LIVES);
      score_q     <= SCORE_W'(0);
      inv_q       <= INV_W'(0);
      hit_pulse_q <= 1'b0;
    end else begin
      hit_pulse_q <= 1'b0;
      if (tick_play_s) begin
        y_q   <= y_d;
        vel_q <= clamp_s ? VEL_W'(0) : vel_d;
        dir_q <= dir_d;
        if (hit_s) begin
          lives_q     <= lives_q - LIVES_W'(1);
          inv_q       <= INV_W'(INVULN_FRAMES);
          hit_pulse_q <= 1'b1;
        end else if (inv_q != INV_W'(0)) begin
          inv_q <= inv_q - INV_W'(1);
        end
        if (last_life_s) begin
          state_q <= ST_OVER;
        end else begin
          if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + SCORE_W'(1);
          if (sw[2]) state_q <= ST_PAUSE;
        end
      end else begin
        case (state_q)
          ST_INIT:  if (sw[2:1] == 2'b01) state_q <= ST_PLAY;
          ST_PLAY:  if (sw[2]) state_q <= ST_PAUSE;
          ST_PAUSE: if (sw[2:1] == 2'b01) state_q <= ST_PLAY;
          default:  state_q <= state_q;
        endcase
      end
    end
  end

  assign gamemode   = state_q;
  assign player_y   = y_q;
  assign lives_left = lives_q;
  assign score      = score_q;
  assign invuln     = (inv_q != INV_W'(0));
  assign hit_pulse  = hit_pulse_q;

endmodule

// File: tb/tb_game_physics_ctrl.sv
// Directed + randomized bench for game_physics_ctrl against an integer reference model.
module tb_game_physics_ctrl;
  localparam int N_OBS = 10;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   frame_tick;
  logic [2:0]             sw;
  logic [N_OBS*2*X_W-1:0] obstacle_x;
  logic [N_OBS*2*Y_W-1:0] obstacle_y;
  logic [1:0]             gamemode;
  logic [Y_W-1:0]         player_y;
  logic [1:0]             lives_left;
  logic [15:0]            score;
  logic                   invuln;
  logic                   hit_pulse;

  int vectors = 0;
  int miscompares = 0;
  int ol[N_OBS], orr[N_OBS], ot[N_OBS], ob[N_OBS];
  int m_mode, m_y, m_v, m_dir, m_lives, m_score, m_inv, m_hit;

  game_physics_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .sw(sw),
    .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
    .gamemode(gamemode), .player_y(player_y), .lives_left(lives_left),
    .score(score), .invuln(invuln), .hit_pulse(hit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_y = 220; m_v = 0; m_dir = 0;
    m_lives = 3; m_score = 0; m_inv = 0; m_hit = 0;
  endtask

  task automatic set_obs(input int k, input int l, input int r, input int t, input int b);
    ol[k] = l; orr[k] = r; ot[k] = t; ob[k] = b;
    obstacle_x[k*2*X_W +: X_W]     = X_W'(l);
    obstacle_x[k*2*X_W+X_W +: X_W] = X_W'(r);
    obstacle_y[k*2*Y_W +: Y_W]     = Y_W'(t);
    obstacle_y[k*2*Y_W+Y_W +: Y_W] = Y_W'(b);
  endtask

  task automatic clear_obs();
    for (int k = 0; k < N_OBS; k++) set_obs(k, 600, 700, 0, 10);
  endtask

  // One rising edge of the game as the rules describe it
  task automatic m_edge(input logic tk, input logic [2:0] s);
    int want_down, ny, ov;
    m_hit = 0;
    if (s[2:1] == 2'b00) begin
      m_reset();
      return;
    end
    if (m_mode == 1 && tk) begin
      ov = 0;
      for (int k = 0; k < N_OBS; k++)
        if (ol[k] <= 140 && orr[k] >= 100 && ot[k] <= m_y + 40 && ob[k] >= m_y) ov = 1;
      want_down = s[0] ? 0 : 1;
      if (m_dir == want_down) m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
      else if (m_v >= 1) m_v = m_v - 1;
      else begin m_v = 1 - m_v; m_dir = 1 - m_dir; end
      ny = m_dir ? m_y + m_v : m_y - m_v;
      if (ny < 20) begin ny = 20; m_v = 0; end
      else if (ny > 420) begin ny = 420; m_v = 0; end
      m_y = ny;
      if (ov && m_inv == 0) begin m_lives--; m_inv = 30; m_hit = 1; end
      else if (m_inv > 0) m_inv--;
      if (m_lives == 0) m_mode = 3;
      else begin
        if (m_score < 65535) m_score++;
        if (s[2]) m_mode = 2;
      end
    end else begin
      if (m_mode == 0 && s[2:1] == 2'b01) m_mode = 1;
      else if (m_mode == 1 && s[2]) m_mode = 2;
      else if (m_mode == 2 && s[2:1] == 2'b01) m_mode = 1;
    end
  endtask

  task automatic check_all();
    check("gamemode", 32'(gamemode), m_mode);
    check("player_y", 32'(player_y), m_y);
    check("lives", 32'(lives_left), m_lives);
    check("score", 32'(score), m_score);
    check("invuln", 32'(invuln), (m_inv != 0) ? 1 : 0);
    check("hit_pulse", 32'(hit_pulse), m_hit);
  endtask

  task automatic step(input logic tk, input logic [2:0] s);
    frame_tick = tk;
    sw = s;
    @(posedge clk);
    m_edge(tk, s);
    #1;
    check_all();
  endtask

  initial begin
    int sy, ss, hits;
    logic [2:0] rs;
    rst = 1'b1; frame_tick = 1'b0; sw = 3'b000;
    obstacle_x = '0; obstacle_y = '0;
    clear_obs();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Free fall from the start position
    step(1'b0, 3'b010);
    check("enter_play", 32'(gamemode), 1);
    step(1'b1, 3'b010); check("fall_t1", 32'(player_y), 221);
    step(1'b0, 3'b010); check("hold_no_tick", 32'(player_y), 221);
    step(1'b1, 3'b010); check("fall_t2", 32'(player_y), 223);
    step(1'b1, 3'b010); check("fall_t3", 32'(player_y), 226);
    for (int i = 0; i < 60; i++) step(1'b1, 3'b010);
    check("floor_clamp", 32'(player_y), 420);
    step(1'b1, 3'b011); check("lift_off", 32'(player_y), 419);

    // Pause freezes everything
    step(1'b0, 3'b100);
    sy = 32'(player_y); ss = 32'(score);
    for (int i = 0; i < 50; i++) step(1'b1, 3'b100);
    check("pause_mode", 32'(gamemode), 2);
    check("pause_y", 32'(player_y), sy);
    check("pause_score", 32'(score), ss);
    step(1'b0, 3'b010);
    check("resume_y", 32'(player_y), sy);
    step(1'b1, 3'b010);
    check("resume_score", 32'(score), ss + 1);

    // Collision with invulnerability window, two overlapping channels
    step(1'b0, 3'b000);
    check("init_lives", 32'(lives_left), 3);
    set_obs(0, 90, 150, 200, 260);
    set_obs(3, 120, 130, 210, 230);
    step(1'b0, 3'b010);
    hits = 0;
    for (int t = 0; t <= 62; t++) begin
      step(1'b1, (t % 2 == 0) ? 3'b011 : 3'b010);
      if (t == 0) begin
        check("first_hit", 32'(hit_pulse), 1);
        check("lives_after_hit", 32'(lives_left), 2);
      end
      if (t >= 1 && t <= 30 && hit_pulse) hits++;
      if (t == 30) check("lives_t30", 32'(lives_left), 2);
      if (t == 31) check("lives_t31", 32'(lives_left), 1);
    end
    check("no_rehit", hits, 0);
    check("over_mode", 32'(gamemode), 3);
    check("over_lives", 32'(lives_left), 0);
    sy = 32'(player_y);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b011);
    check("over_ignore", 32'(gamemode), 3);
    check("over_frozen", 32'(player_y), sy);
    step(1'b0, 3'b000);
    check("restart_mode", 32'(gamemode), 0);
    check("restart_lives", 32'(lives_left), 3);

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        clear_obs();
        for (int k = 0; k < N_OBS; k += 2) begin
          int l, t;
          l = $urandom_range(0, 300);
          t = $urandom_range(0, 480);
          set_obs(k, l, l + $urandom_range(0, 100), t, t + $urandom_range(0, 30));
        end
      end
      case ($urandom_range(0, 99)) inside
        [0:1]:   rs = 3'b000;
        [2:5]:   rs = {2'($urandom_range(2, 3)), 1'($urandom_range(0, 1))};
        default: rs = {2'b01, 1'($urandom_range(0, 1))};
      endcase
      step(1'($urandom_range(0, 2) != 0), rs);
    end

    // Asynchronous reset in the middle of play
    clear_obs();
    step(1'b0, 3'b000);
    step(1'b0, 3'b010);
    for (int i = 0; i < 20; i++) step(1'b1, 3'b010);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check("arst_mode", 32'(gamemode), 0);
    check("arst_y", 32'(player_y), 220);
    check("arst_lives", 32'(lives_left), 3);
    check("arst_score", 32'(score), 0);
    check("arst_invuln", 32'(invuln), 0);
    check("arst_hit", 32'(hit_pulse), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
